w8_rotator_pipe: RTL and testbench

Pipelined, parametrised complex rotator by the eighth roots of unity W8^k = e^(-j2πk/8), k = 0..7, for the radix-8 stages of the 64-point FFT datapath. Odd k multiply by √2/2 using a multiplierless shift-add constant (5793/8192 = 2^-13·(2^12+2^10+2^9+2^7+2^5+2^0)). Even k are trivial swap/negate. The block sits between the butterfly output and the next stage. It adds valid/ready flow control, a sideband tag, saturation, and optional rounding.

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/w8_rotator_pipe_if.sv | 32 +++
 rtl/w8_sqrt2_scale.sv | 81 ++++++++
 rtl/w8_rotator_pipe.sv | 137 +++++++++++++
 tb/tb_w8_rotator_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: W8 twiddle index, sqrt(2)/2 constant,
// shift-add decomposition and the component saturate function.
package fft_pkg;

  localparam int SQRT2_Q13  = 5793;
  localparam int SQRT2_FRAC = 13;

  // 5793 = 2^0 + 2^5 + 2^7 + 2^9 + 2^10 + 2^12
  localparam int W8_SHIFTS [6] = '{0, 5, 7, 9, 10, 12};

  typedef enum logic [2:0] {
    W8_0 = 3'd0,
    W8_1 = 3'd1,
    W8_2 = 3'd2,
    W8_3 = 3'd3,
    W8_4 = 3'd4,
    W8_5 = 3'd5,
    W8_6 = 3'd6,
    W8_7 = 3'd7
  } w8_idx_t;

  // Clip x to a dw-bit two's-complement range; hit flags clipping.
  function automatic logic signed [63:0] saturate(
    input  logic signed [63:0] x,
    input  int                 dw,
    output logic               hit
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    hit = 1'b0;
    r   = x;
    if (x > hi) begin
      r   = hi;
      hit = 1'b1;
    end else if (x < lo) begin
      r   = lo;
      hit = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/w8_rotator_pipe_if.sv
// Stream bundle of the W8 rotator: input sample/k/tag with valid/ready,
// output sample/tag/sat with valid/ready. slave = rotator, master = source/sink.
interface w8_rotator_pipe_if
  import fft_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TAGW = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_re;
  logic [DW-1:0]   in_im;
  w8_idx_t         in_k;
  logic [TAGW-1:0] in_tag;

  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_re;
  logic [DW-1:0]   out_im;
  logic [TAGW-1:0] out_tag;
  logic            out_sat;

  modport master (
    output in_valid, in_re, in_im, in_k, in_tag, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_tag, out_sat
  );

  modport slave (
    input  in_valid, in_re, in_im, in_k, in_tag, out_ready,
    output in_ready, out_valid, out_re, out_im, out_tag, out_sat
  );
endinterface

// File: rtl/w8_sqrt2_scale.sv
// Stages 2-3 for one component: x*sqrt(2)/2 by shift-add (odd k) or bypass
// (even k), then saturate. Ports: clk, rst_n, en (stall), odd, x -> y, sat.
// W8_ROUND_EN: round half up before the >>13 on odd k.
module w8_sqrt2_scale
  import fft_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 odd,
  input  logic signed [DW+1:0] x,
  output logic signed [DW-1:0] y,
  output logic                 sat
);

  localparam int XW = DW + 2;
  localparam int PW = DW + 15;

  logic signed [PW-1:0] xe;
  logic signed [PW-1:0] pa;
  logic signed [PW-1:0] pb;
  logic signed [PW-1:0] pc;
  logic signed [XW-1:0] xd;
  logic                 odd_d;

  logic signed [PW-1:0] sum;
  logic signed [PW-1:0] shr;
  logic signed [63:0]   wide;
  logic signed [63:0]   clip;
  logic [63-DW:0]       unused_hi;
  logic signed [DW-1:0] y_n;
  logic                 hit;

  assign xe = {{(PW-XW){x[XW-1]}}, x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa    <= '0;
      pb    <= '0;
      pc    <= '0;
      xd    <= '0;
      odd_d <= 1'b0;
    end else if (en) begin
      pa    <= (xe <<< W8_SHIFTS[0]) + (xe <<< W8_SHIFTS[1]);
      pb    <= (xe <<< W8_SHIFTS[2]) + (xe <<< W8_SHIFTS[3]);
      pc    <= (xe <<< W8_SHIFTS[4]) + (xe <<< W8_SHIFTS[5]);
      xd    <= x;
      odd_d <= odd;
    end
  end

`ifdef W8_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (SQRT2_FRAC - 1);
`endif

  always_comb begin
    sum = pa + pb + pc;
`ifdef W8_ROUND_EN
    sum = sum + HALF;
`endif
    shr  = sum >>> SQRT2_FRAC;
    wide = odd_d ? {{(64-PW){shr[PW-1]}}, shr}
                 : {{(64-XW){xd[XW-1]}}, xd};
    hit  = 1'b0;
    clip = saturate(wide, DW, hit);
    {unused_hi, y_n} = clip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      y   <= y_n;
      sat <= hit;
    end
  end

endmodule

// File: rtl/w8_rotator_pipe.sv
// Pipelined rotator by W8^k with global-stall valid/ready, tag, saturation.
// Ports: clk, rst_n, bus (slave: in_*/out_*). Option macro: W8_ROUND_EN.
module w8_rotator_pipe
  import fft_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TAGW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  w8_rotator_pipe_if.slave  bus
);

  localparam int XW = DW + 2;

  logic adv;
  logic v0;
  logic v1;
  logic v2;
  logic vo;

  logic signed [DW-1:0] a0;
  logic signed [DW-1:0] b0;
  w8_idx_t              k0;
  logic [TAGW-1:0]      t0;

  logic signed [XW-1:0] ax;
  logic signed [XW-1:0] bx;
  logic signed [XW-1:0] pn;
  logic signed [XW-1:0] qn;

  logic signed [XW-1:0] p1;
  logic signed [XW-1:0] q1;
  logic                 odd1;
  logic [TAGW-1:0]      t1;
  logic [TAGW-1:0]      t2;
  logic [TAGW-1:0]      to;

  logic signed [DW-1:0] y_re;
  logic signed [DW-1:0] y_im;
  logic                 s_re;
  logic                 s_im;

  assign adv          = ~vo | bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      vo <= 1'b0;
    end else if (adv) begin
      v0 <= bus.in_valid;
      v1 <= v0;
      v2 <= v1;
      vo <= v2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0 <= '0;
      b0 <= '0;
      k0 <= W8_0;
      t0 <= '0;
    end else if (adv) begin
      a0 <= bus.in_re;
      b0 <= bus.in_im;
      k0 <= bus.in_k;
      t0 <= bus.in_tag;
    end
  end

  // Stage 1: multiply by W8^k up to the common sqrt(2)/2 factor.
  always_comb begin
    ax = {{2{a0[DW-1]}}, a0};
    bx = {{2{b0[DW-1]}}, b0};
    pn = ax;
    qn = bx;
    unique case (1'b1)
      k0 == W8_1: begin pn = ax + bx;  qn = bx - ax;  end
      k0 == W8_2: begin pn = bx;       qn = -ax;      end
      k0 == W8_3: begin pn = bx - ax;  qn = -ax - bx; end
      k0 == W8_4: begin pn = -ax;      qn = -bx;      end
      k0 == W8_5: begin pn = -ax - bx; qn = ax - bx;  end
      k0 == W8_6: begin pn = -bx;      qn = ax;       end
      k0 == W8_7: begin pn = ax - bx;  qn = ax + bx;  end
      default:    begin pn = ax;       qn = bx;       end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1   <= '0;
      q1   <= '0;
      odd1 <= 1'b0;
      t1   <= '0;
      t2   <= '0;
      to   <= '0;
    end else if (adv) begin
      p1   <= pn;
      q1   <= qn;
      odd1 <= k0[0];
      t1   <= t0;
      t2   <= t1;
      to   <= t2;
    end
  end

  w8_sqrt2_scale #(.DW(DW)) u_re (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .odd   (odd1),
    .x     (p1),
    .y     (y_re),
    .sat   (s_re)
  );

  w8_sqrt2_scale #(.DW(DW)) u_im (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .odd   (odd1),
    .x     (q1),
    .y     (y_im),
    .sat   (s_im)
  );

  assign bus.out_valid = vo;
  assign bus.out_re    = y_re;
  assign bus.out_im    = y_im;
  assign bus.out_tag   = to;
  assign bus.out_sat   = s_re | s_im;

endmodule

// File: tb/tb_w8_rotator_pipe.sv
// Bench for w8_rotator_pipe: directed vectors, random stream,
// backpressure and mid-stream reset against a complex-multiply model.
module tb_w8_rotator_pipe;
  import fft_pkg::*;

  localparam int DW   = 16;
  localparam int TAGW = 6;
`ifdef W8_ROUND_EN
  localparam longint RND = 4096;
  localparam int     R1  = 1;
`else
  localparam longint RND = 0;
  localparam int     R1  = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  typedef struct {
    int re;
    int im;
    bit sat;
    int tag;
    int acc;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int k;
    int re;
    int im;
    bit sat;
  } vec_t;

  exp_t sb[$];

  w8_rotator_pipe_if #(.DW(DW), .TAGW(TAGW)) bus ();

  w8_rotator_pipe #(.DW(DW), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // (a+jb) * W8^k, odd k carried as (1 -+ j) times sqrt(2)/2 in Q13
  function automatic exp_t model(input int a, input int b, input int k,
                                 input int tag);
    int     cr [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int     ci [8] = '{0, -1, -1, -1, 0, 1, 1, 1};
    longint p, q, hi, lo;
    exp_t   e;
    p = longint'(a) * cr[k] - longint'(b) * ci[k];
    q = longint'(a) * ci[k] + longint'(b) * cr[k];
    if (k % 2 == 1) begin
      p = (p * 5793 + RND) >>> 13;
      q = (q * 5793 + RND) >>> 13;
    end
    hi = (64'sd1 <<< (DW - 1)) - 1;
    lo = -(64'sd1 <<< (DW - 1));
    e.sat = 1'b0;
    if (p > hi) begin p = hi; e.sat = 1'b1; end
    if (p < lo) begin p = lo; e.sat = 1'b1; end
    if (q > hi) begin q = hi; e.sat = 1'b1; end
    if (q < lo) begin q = lo; e.sat = 1'b1; end
    e.re  = int'(p);
    e.im  = int'(q);
    e.tag = tag;
    e.acc = 0;
    return e;
  endfunction

  function automatic int rcomp();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($signed(16'($urandom)));
  endfunction

  task automatic drive(input int a, input int b, input int k, input int tag);
    bus.in_valid = 1'b1;
    bus.in_re    = DW'(a);
    bus.in_im    = DW'(b);
    bus.in_k     = w8_idx_t'(3'(k));
    bus.in_tag   = TAGW'(tag);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_k      = W8_0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_re !== '0 || bus.out_im !== '0) begin
      errors++; $display("FAIL reset_data got %h %h want 0", bus.out_re, bus.out_im);
    end
    checks++;
    if (bus.out_tag !== '0 || bus.out_sat !== 1'b0) begin
      errors++; $display("FAIL reset_tag got %h %b want 0", bus.out_tag, bus.out_sat);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v [6];
    int   acc;
    bit   got;
    v[0] = '{100, -200, 2, -200, -100, 1'b0};
    v[1] = '{1000, 1000, 1, 1414, 0, 1'b0};
    v[2] = '{1, 0, 1, R1, -1, 1'b0};
    v[3] = '{-32768, -32768, 1, -32768, 0, 1'b1};
    v[4] = '{-32768, -32768, 3, 0, 32767, 1'b1};
    v[5] = '{-32768, 0, 2, 0, 32767, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive(v[i].a, v[i].b, v[i].k, 20 + i);
      #1;
      acc = edges + 1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
        if (bus.out_valid) got = 1'b1;
        else begin @(posedge clk); #1; end
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL dir%0d_timeout no output", i);
      end else begin
        checks++;
        if (edges - acc != 3) begin
          errors++; $display("FAIL dir%0d_latency got %0d want 3", i, edges - acc);
        end
        checks++;
        if (int'($signed(bus.out_re)) != v[i].re || int'($signed(bus.out_im)) != v[i].im) begin
          errors++;
          $display("FAIL dir%0d_data got (%0d,%0d) want (%0d,%0d)", i,
                   $signed(bus.out_re), $signed(bus.out_im), v[i].re, v[i].im);
        end
        checks++;
        if (bus.out_sat !== v[i].sat || int'(bus.out_tag) != 20 + i) begin
          errors++;
          $display("FAIL dir%0d_sattag got %b/%0d want %b/%0d", i,
                   bus.out_sat, bus.out_tag, v[i].sat, 20 + i);
        end
      end
    end
  endtask

  task automatic test_stream();
    int   sent = 0;
    int   rcvd = 0;
    int   a, b;
    exp_t e;
    sb.delete();
    for (int c = 0; c < 300 && rcvd < 64; c++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      if (sent < 64) begin
        a = rcomp(); b = rcomp();
        drive(a, b, sent % 8, sent);
      end else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_extra got tag %0d want none", bus.out_tag);
        end else begin
          e = sb.pop_front();
          if (int'($signed(bus.out_re)) != e.re || int'($signed(bus.out_im)) != e.im ||
              bus.out_sat !== e.sat || int'(bus.out_tag) != e.tag || edges != e.acc + 3) begin
            errors++;
            $display("FAIL stream_out got (%0d,%0d,%b,t%0d,e%0d) want (%0d,%0d,%b,t%0d,e%0d)",
                     $signed(bus.out_re), $signed(bus.out_im), bus.out_sat, bus.out_tag,
                     edges, e.re, e.im, e.sat, e.tag, e.acc + 3);
          end
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(a, b, sent % 8, sent % 64);
        e.acc = edges + 1;
        sb.push_back(e);
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (rcvd != 64 || sb.size() != 0) begin
      errors++; $display("FAIL stream_count got %0d want 64", rcvd);
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 120;
    int   sent = 0;
    int   rcvd = 0;
    bit   pend = 1'b0;
    bit   stalled = 1'b0;
    int   a = 0, b = 0, k = 0;
    exp_t e;
    logic [DW-1:0]   s_re, s_im;
    logic [TAGW-1:0] s_tag;
    logic            s_sat;
    sb.delete();
    for (int c = 0; c < 3000 && rcvd < N; c++) begin
      @(posedge clk); #1;
      if (!pend) begin
        if (sent < N && $urandom_range(0, 3) != 0) begin
          a = rcomp(); b = rcomp(); k = int'($urandom_range(0, 7));
          drive(a, b, k, sent);
          pend = 1'b1;
        end else bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus.in_ready !== (~bus.out_valid | bus.out_ready)) begin
        errors++; $display("FAIL bp_in_ready got %b want %b", bus.in_ready,
                           ~bus.out_valid | bus.out_ready);
      end
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_re !== s_re || bus.out_im !== s_im ||
            bus.out_tag !== s_tag || bus.out_sat !== s_sat) begin
          errors++;
          $display("FAIL bp_hold got %b %h %h %0d want 1 %h %h %0d",
                   bus.out_valid, bus.out_re, bus.out_im, bus.out_tag, s_re, s_im, s_tag);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      s_re = bus.out_re; s_im = bus.out_im; s_tag = bus.out_tag; s_sat = bus.out_sat;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra got tag %0d want none", bus.out_tag);
        end else begin
          e = sb.pop_front();
          if (int'($signed(bus.out_re)) != e.re || int'($signed(bus.out_im)) != e.im ||
              bus.out_sat !== e.sat || int'(bus.out_tag) != e.tag) begin
            errors++;
            $display("FAIL bp_out got (%0d,%0d,%b,t%0d) want (%0d,%0d,%b,t%0d)",
                     $signed(bus.out_re), $signed(bus.out_im), bus.out_sat, bus.out_tag,
                     e.re, e.im, e.sat, e.tag);
          end
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(a, b, k, sent % 64));
        sent++;
        pend = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (rcvd != N || sb.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d want %0d", rcvd, N);
    end
  endtask

  task automatic test_mid_reset();
    int acc;
    int nvalid = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(rcomp(), rcomp(), i, 40 + i);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || int'(bus.out_tag) != 40) begin
      errors++; $display("FAIL mr_pre got %b/%0d want 1/40", bus.out_valid, bus.out_tag);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mr_async got %b/%b want 0/1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_re !== '0 || bus.out_im !== '0 || bus.out_tag !== '0 || bus.out_sat !== 1'b0) begin
      errors++; $display("FAIL mr_zero got %h %h %h %b want 0", bus.out_re, bus.out_im,
                         bus.out_tag, bus.out_sat);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(300, -50, 4, 7);
    #1;
    acc = edges + 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        nvalid++;
        checks++;
        if (edges != acc + 3 || int'(bus.out_tag) != 7 ||
            int'($signed(bus.out_re)) != -300 || int'($signed(bus.out_im)) != 50) begin
          errors++;
          $display("FAIL mr_out got e%0d t%0d (%0d,%0d) want e%0d t7 (-300,50)",
                   edges, bus.out_tag, $signed(bus.out_re), $signed(bus.out_im), acc + 3);
        end
      end
    end
    checks++;
    if (nvalid != 1) begin
      errors++; $display("FAIL mr_count got %0d want 1", nvalid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
